// File: rtl/mainmemory_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM states, bus
// widths and the latched command record.
package mainmemory_pkg;

  localparam int MEM_AW = 27;
  localparam int LINE_W = 256;
  localparam int BE_W   = 32;
  localparam int NPORT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] a;
    logic [BE_W-1:0]   be;
    logic [LINE_W-1:0] wd;
    logic              port;
  } cmd_t;

  function automatic logic [NPORT-1:0] port_mask(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mainmemory_arbiter_rr.sv
// Two-port round-robin grant: on contention the port that was not granted
// last wins; a lone requester always wins. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mainmemory_arbiter.sv
// Sequencer and two-port arbiter in front of the line-wide main memory:
// one access outstanding, single-cycle read/write pulse, payload held to RESP.
module mainmemory_arbiter
  import mainmemory_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT-1:0]        req_we,
  input  logic [NPORT*MEM_AW-1:0] req_a,
  input  logic [NPORT*BE_W-1:0]   req_be,
  input  logic [NPORT*LINE_W-1:0] req_wd,
  output logic [NPORT-1:0]        done,
  output logic [NPORT-1:0]        err,
  output logic [LINE_W-1:0]       rd_data,
  output logic                    busy,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [MEM_AW-1:0]       mem_a,
  output logic [BE_W-1:0]         mem_be,
  output logic [LINE_W-1:0]       mem_wd,
  input  logic [LINE_W-1:0]       mem_rd,
  input  logic                    mem_valid,
  input  logic                    mem_ready
);

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        last_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_err_q, resp_err_d;
  logic        cmd_load;
  logic        capture;
  logic [1:0]  grant;
  logic        win;
  logic        out_of_range;

  rr_arbiter2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  assign win = grant[1];

  always_comb begin
    cmd_d.we   = req_we[win];
    cmd_d.a    = win ? req_a[2*MEM_AW-1:MEM_AW]   : req_a[MEM_AW-1:0];
    cmd_d.be   = win ? req_be[2*BE_W-1:BE_W]      : req_be[BE_W-1:0];
    cmd_d.wd   = win ? req_wd[2*LINE_W-1:LINE_W]  : req_wd[LINE_W-1:0];
    cmd_d.port = win;
  end

  assign out_of_range = 32'(cmd_d.a) >= 32'(ENTRIES);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;
    cmd_load   = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          cmd_load   = 1'b1;
          resp_err_d = out_of_range;
          state_d    = out_of_range ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Only the response matching the command type ends the wait.
        if (!cmd_q.we && mem_valid) begin
          capture    = 1'b1;
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
        end else if (cmd_q.we && mem_ready) begin
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          resp_err_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= 8'd0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
      if (cmd_load) begin
        last_q <= win;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= '0;
      rd_data <= '0;
    end else begin
      if (cmd_load) begin
        cmd_q <= cmd_d;
      end
      if (capture) begin
        rd_data <= mem_rd;
      end
    end
  end

  // The pulse exists only in ISSUE, which always lasts a single cycle.
  assign busy      = (state_q != ST_IDLE);
  assign mem_read  = (state_q == ST_ISSUE) && !cmd_q.we;
  assign mem_write = (state_q == ST_ISSUE) &&  cmd_q.we;
  assign mem_a     = cmd_q.a;
  assign mem_be    = cmd_q.be;
  assign mem_wd    = cmd_q.wd;
  assign done      = (state_q == ST_RESP) ? port_mask(cmd_q.port) : 2'b00;
  assign err       = (state_q == ST_RESP && resp_err_q) ? port_mask(cmd_q.port) : 2'b00;

endmodule

// File: tb/tb_mainmemory_arbiter.sv
// Bench for mainmemory_arbiter: behavioural main memory responder plus
// scenario tasks checking results against a queue of expected completions.
module tb_mainmemory_arbiter;
  import mainmemory_pkg::*;

  localparam int ENTRIES = 256;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req, req_we;
  logic [53:0]  req_a;
  logic [63:0]  req_be;
  logic [511:0] req_wd;
  logic [1:0]   done, err;
  logic [255:0] rd_data;
  logic         busy, mem_read, mem_write;
  logic [26:0]  mem_a;
  logic [31:0]  mem_be;
  logic [255:0] mem_wd, mem_rd;
  logic         mem_valid, mem_ready;

  mainmemory_arbiter #(.ENTRIES(ENTRIES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_a(req_a),
    .req_be(req_be), .req_wd(req_wd), .done(done), .err(err),
    .rd_data(rd_data), .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] LINE_A5  = {32{8'hA5}};
  localparam logic [255:0] LINE_W   = {16{16'h1234}};
  localparam logic [255:0] LINE_OTH = {8{32'hDEADBEEF}};
  localparam logic [255:0] LINE_BAD = {8{32'hBADBAD00}};

  typedef struct {
    logic [1:0]   done;
    logic [1:0]   err;
    logic [255:0] data;
    logic         chk_data;
    int           lat;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] mem [0:255];
  int  cyc = 0;
  int  rd_cnt = 0, wr_cnt = 0;
  logic [7:0] rd_addr, wr_addr;
  bit  suppress = 0;
  bit  force_valid = 0;
  int  n_rd = 0, n_wr = 0, n_viol = 0;
  int  last_rd_cyc = -1, last_wr_cyc = -1;
  bit  prev_pulse = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Main memory model: data two cycles after the read pulse; write data
  // taken one cycle after the write pulse, ready one cycle later.
  initial begin
    mem_valid = 1'b0;
    mem_ready = 1'b0;
    mem_rd    = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_ready = 1'b0;
      if (force_valid) begin
        mem_valid   = 1'b1;
        mem_rd      = LINE_BAD;
        force_valid = 0;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0 && !suppress) begin
          mem_valid = 1'b1;
          mem_rd    = mem[rd_addr];
        end
      end
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 1) mem[wr_addr] = mem_wd;
        if (wr_cnt == 0) mem_ready = 1'b1;
      end
      if (mem_read) begin
        rd_cnt = 2; rd_addr = mem_a[7:0]; n_rd++; last_rd_cyc = cyc;
      end
      if (mem_write) begin
        wr_cnt = 2; wr_addr = mem_a[7:0]; n_wr++; last_wr_cyc = cyc;
      end
      if ((mem_read || mem_write) && prev_pulse) n_viol++;
      prev_pulse = mem_read || mem_write;
    end
  end

  task automatic drive_port(input int p, input logic we, input logic [26:0] a,
                            input logic [255:0] wd);
    req_we[p]            = we;
    req_a[27*p +: 27]    = a;
    req_be[32*p +: 32]   = '1;
    req_wd[256*p +: 256] = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a done pulse; lat = -1 when the budget runs out.
  task automatic wait_done(input int budget, output int lat, output logic [1:0] d,
                           output logic [1:0] e, output logic [255:0] r);
    lat = -1; d = 'x; e = 'x; r = 'x;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (|done) begin
        lat = i; d = done; e = err; r = rd_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_we = '0; req_a = '0; req_be = '0; req_wd = '0;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL reset_done_err: got %b/%b expected 00/00", done, err); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b expected 00", {mem_read, mem_write}); end
    n_cmp++; if (mem_a !== '0 || mem_be !== '0 || mem_wd !== '0 || rd_data !== '0) begin
      n_bad++; $display("FAIL reset_data: got a=%h be=%h expected zeros", mem_a, mem_be);
    end
    reset = 1'b0;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_read();
    int lat; logic [1:0] d, e; logic [255:0] r; exp_t x; int c0, n0;
    step();
    drive_port(0, 1'b0, 27'd5, LINE_OTH);
    sb.push_back('{done: 2'b01, err: 2'b00, data: LINE_A5, chk_data: 1'b1, lat: 4});
    c0 = cyc; n0 = n_rd;
    req = 2'b01;
    wait_done(20, lat, d, e, r);
    req = 2'b00;
    x = sb.pop_front();
    n_cmp++; if (lat !== x.lat) begin n_bad++; $display("FAIL read_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (d !== x.done || e !== x.err) begin n_bad++; $display("FAIL read_done_err: got %b/%b expected %b/%b", d, e, x.done, x.err); end
    n_cmp++; if (r !== x.data) begin n_bad++; $display("FAIL read_data: got %h expected %h", r, x.data); end
    n_cmp++; if (last_rd_cyc !== c0 + 1) begin n_bad++; $display("FAIL read_pulse_cycle: got %0d expected %0d", last_rd_cyc, c0 + 1); end
    n_cmp++; if (n_rd - n0 !== 1) begin n_bad++; $display("FAIL read_pulse_count: got %0d expected 1", n_rd - n0); end
  endtask

  task automatic test_write_then_read();
    int lat; logic [1:0] d, e; logic [255:0] r; exp_t x; int c0; int unstable;
    step();
    drive_port(1, 1'b1, 27'd3, LINE_W);
    drive_port(0, 1'b0, 27'd3, LINE_OTH);
    sb.push_back('{done: 2'b10, err: 2'b00, data: '0, chk_data: 1'b0, lat: 4});
    c0 = cyc; unstable = 0; d = 'x; e = 'x;
    req = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (mem_wd !== LINE_W || mem_a !== 27'd3) unstable++;
      if (k == 4) begin d = done; e = err; end
    end
    req = 2'b00;
    x = sb.pop_front();
    n_cmp++; if (d !== x.done || e !== x.err) begin n_bad++; $display("FAIL write_done_err: got %b/%b expected %b/%b", d, e, x.done, x.err); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL write_hold: got %0d unstable cycles expected 0", unstable); end
    n_cmp++; if (last_wr_cyc !== c0 + 1) begin n_bad++; $display("FAIL write_pulse_cycle: got %0d expected %0d", last_wr_cyc, c0 + 1); end
    n_cmp++; if (mem[3] !== LINE_W) begin n_bad++; $display("FAIL write_stored: got %h expected %h", mem[3], LINE_W); end
    step();
    sb.push_back('{done: 2'b01, err: 2'b00, data: LINE_W, chk_data: 1'b1, lat: 4});
    req = 2'b01;
    wait_done(20, lat, d, e, r);
    req = 2'b00;
    x = sb.pop_front();
    n_cmp++; if (lat !== x.lat || d !== x.done || e !== x.err) begin
      n_bad++; $display("FAIL readback_done: got lat=%0d %b/%b expected lat=%0d %b/%b", lat, d, e, x.lat, x.done, x.err);
    end
    n_cmp++; if (r !== x.data) begin n_bad++; $display("FAIL readback_data: got %h expected %h", r, x.data); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [1:0] d, e; logic [255:0] r; exp_t x; int v0;
    reset = 1'b1;
    drive_port(0, 1'b0, 27'd5, LINE_OTH);
    drive_port(1, 1'b0, 27'd3, LINE_OTH);
    req = 2'b11;
    step(); step();
    v0 = n_viol;
    for (int j = 0; j < 4; j++) begin
      sb.push_back('{done: (j % 2 == 0) ? 2'b01 : 2'b10, err: 2'b00,
                     data: (j % 2 == 0) ? LINE_A5 : LINE_W, chk_data: 1'b1,
                     lat: (j == 0) ? 4 : 5});
    end
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_done(20, lat, d, e, r);
      if (j == 3) req = 2'b00;
      x = sb.pop_front();
      n_cmp++; if (lat !== x.lat) begin n_bad++; $display("FAIL b2b_spacing_%0d: got %0d expected %0d", j, lat, x.lat); end
      n_cmp++; if (d !== x.done || e !== x.err) begin n_bad++; $display("FAIL b2b_grant_%0d: got %b/%b expected %b/%b", j, d, e, x.done, x.err); end
      n_cmp++; if (r !== x.data) begin n_bad++; $display("FAIL b2b_data_%0d: got %h expected %h", j, r, x.data); end
    end
    n_cmp++; if (n_viol - v0 !== 0) begin n_bad++; $display("FAIL b2b_adjacent_pulses: got %0d expected 0", n_viol - v0); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [1:0] d, e; logic [255:0] r; exp_t x; int r0, w0;
    step();
    drive_port(0, 1'b0, 27'(ENTRIES), LINE_OTH);
    sb.push_back('{done: 2'b01, err: 2'b01, data: '0, chk_data: 1'b0, lat: 1});
    r0 = n_rd; w0 = n_wr;
    req = 2'b01;
    wait_done(20, lat, d, e, r);
    req = 2'b00;
    x = sb.pop_front();
    n_cmp++; if (lat !== x.lat) begin n_bad++; $display("FAIL oor_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (d !== x.done || e !== x.err) begin n_bad++; $display("FAIL oor_done_err: got %b/%b expected %b/%b", d, e, x.done, x.err); end
    step(); step(); step();
    n_cmp++; if (n_rd !== r0 || n_wr !== w0) begin n_bad++; $display("FAIL oor_no_pulse: got rd=%0d wr=%0d expected rd=%0d wr=%0d", n_rd, n_wr, r0, w0); end
  endtask

  task automatic test_timeout();
    int lat; logic [1:0] d, e; logic [255:0] r; exp_t x; int bad;
    step();
    suppress = 1;
    drive_port(0, 1'b0, 27'd5, LINE_OTH);
    sb.push_back('{done: 2'b01, err: 2'b01, data: '0, chk_data: 1'b0, lat: 2 + TIMEOUT});
    req = 2'b01;
    wait_done(60, lat, d, e, r);
    req = 2'b00;
    x = sb.pop_front();
    n_cmp++; if (lat !== x.lat) begin n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (d !== x.done || e !== x.err) begin n_bad++; $display("FAIL timeout_done_err: got %b/%b expected %b/%b", d, e, x.done, x.err); end
    step();
    suppress = 0;
    force_valid = 1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (|done || busy) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL late_valid_ignored: got %0d active cycles expected 0", bad); end
    n_cmp++; if (rd_data !== LINE_W) begin n_bad++; $display("FAIL late_valid_data: got %h expected %h", rd_data, LINE_W); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [1:0] d, e; logic [255:0] r; exp_t x; int pulses;
    step();
    drive_port(1, 1'b0, 27'd5, LINE_W);
    req = 2'b10;
    step(); step();
    reset = 1'b1;
    #1;
    req = 2'b00;
    n_cmp++; if (busy !== 1'b0 || done !== 2'b00 || err !== 2'b00) begin
      n_bad++; $display("FAIL abort_ctrl: got busy=%b done=%b err=%b expected 0/00/00", busy, done, err);
    end
    n_cmp++; if (mem_read !== 1'b0 || mem_a !== '0 || mem_wd !== '0 || rd_data !== '0) begin
      n_bad++; $display("FAIL abort_data: got rd=%b a=%h expected 0/0", mem_read, mem_a);
    end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (|done) pulses++;
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (|done) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", pulses); end
    sb.push_back('{done: 2'b10, err: 2'b00, data: LINE_A5, chk_data: 1'b1, lat: 4});
    req = 2'b10;
    wait_done(20, lat, d, e, r);
    req = 2'b00;
    x = sb.pop_front();
    n_cmp++; if (lat !== x.lat || d !== x.done || e !== x.err) begin
      n_bad++; $display("FAIL after_reset_done: got lat=%0d %b/%b expected lat=%0d %b/%b", lat, d, e, x.lat, x.done, x.err);
    end
    n_cmp++; if (r !== x.data) begin n_bad++; $display("FAIL after_reset_data: got %h expected %h", r, x.data); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[5] = LINE_A5;
    test_reset();
    test_read();
    test_write_then_read();
    test_back_to_back();
    test_out_of_range();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
